// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: sequencer states, default timing constants and a sizing helper for pll_reset_ctrl.
package pll_reset_pkg;

    typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_HOLD_CYCLES         = 64;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1048576;
    localparam int LLC_W                   = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_bit_sync.sv
// bit_sync: DEPTH-flop synchroniser with synchronous reset to 0.
module bit_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst)
            ff <= '0;
        else
            ff <= DEPTH'({ff, d});
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset and system reset sequencer; define PLL_LOCK_TIMEOUT_EN to re-pulse pll_rst when lock never arrives.
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int HOLD_CYCLES         = DEF_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             reset_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             running,
    output logic [LLC_W-1:0] lock_loss_count
);

    localparam int CW = max2($clog2(max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                         max2(HOLD_CYCLES, LOCK_TIMEOUT_CYCLES))), 1);
    localparam logic [CW-1:0] PLL_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    state_t        state, nxt;
    logic [CW-1:0] count, count_nxt;
    logic          locked_s;

    bit_sync #(.DEPTH(2)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_comb begin
        nxt       = state;
        count_nxt = count + CW'(1);
        case (state)
            PLL_RESET: if (count == PLL_LAST) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
`ifdef PLL_LOCK_TIMEOUT_EN
                if (locked_s) nxt = STABLE;
                else if (count == TIMEOUT_LAST) nxt = PLL_RESET;
`else
                count_nxt = '0;
                if (locked_s) nxt = STABLE;
`endif
            end
            STABLE: begin
                if (!locked_s) nxt = WAIT_LOCK;
                else if (count == STABLE_LAST) nxt = HOLD;
            end
            HOLD: begin
                if (!locked_s) nxt = WAIT_LOCK;
                else if (count == HOLD_LAST) nxt = RUN;
            end
            RUN: begin
                count_nxt = '0;
                // lock loss outranks a coincident reset request
                if (!locked_s) nxt = WAIT_LOCK;
                else if (reset_req) nxt = HOLD;
            end
            default: nxt = PLL_RESET;
        endcase
        if (nxt != state) count_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= PLL_RESET;
            count           <= '0;
            pll_rst         <= 1'b1;
            sys_rst         <= 1'b1;
            running         <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state   <= nxt;
            count   <= count_nxt;
            pll_rst <= (nxt == PLL_RESET);
            sys_rst <= (nxt != RUN);
            running <= (nxt == RUN);
            if (state == RUN && !locked_s && lock_loss_count != '1)
                lock_loss_count <= lock_loss_count + LLC_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: scoreboard bench; a default-parameter instance and a short-timing instance for saturation/timeout.
module tb_pll_reset_ctrl;

    localparam int S_PLL = 0, S_SYS = 1, S_RUN = 2, S_LLC = 3, F = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic       clk = 0, rst = 1, locked = 1, reset_req = 0, locked_f = 1, req_f = 0;
    logic       pll_rst, sys_rst, running, f_pll, f_sys, f_run;
    logic [7:0] llc, f_llc;
    int         cyc = 0, total = 0, bad = 0;
    exp_t       sb[$];
    exp_t       e;

    pll_reset_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .locked          (locked),
        .reset_req       (reset_req),
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .running         (running),
        .lock_loss_count (llc)
    );

    pll_reset_ctrl #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .HOLD_CYCLES         (4),
        .LOCK_TIMEOUT_CYCLES (100)
    ) fst (
        .clk             (clk),
        .rst             (rst),
        .locked          (locked_f),
        .reset_req       (req_f),
        .pll_rst         (f_pll),
        .sys_rst         (f_sys),
        .running         (f_run),
        .lock_loss_count (f_llc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(int s);
        case (s)
            S_PLL:     return 32'(pll_rst);
            S_SYS:     return 32'(sys_rst);
            S_RUN:     return 32'(running);
            S_LLC:     return 32'(llc);
            F + S_PLL: return 32'(f_pll);
            F + S_SYS: return 32'(f_sys);
            F + S_RUN: return 32'(f_run);
            F + S_LLC: return 32'(f_llc);
            default:   return '1;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(int c, int s, logic [31:0] v, string t);
        exp_t x;
        int   i = 0;
        x.cyc = c;
        x.sig = s;
        x.val = v;
        x.tag = t;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, x);
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk)
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sig), e.val);
        end

    initial begin
        int r, t, d, q, f, g;
        repeat (4) @(negedge clk);
        chk("rst_pll", 32'(pll_rst), 1);
        chk("rst_sys", 32'(sys_rst), 1);
        chk("rst_run", 32'(running), 0);
        chk("rst_llc", 32'(llc), 0);

        // power-up with locked held high
        r = cyc;
        rst = 0;
        expect_at(r + 15, S_PLL, 1, "pu_pll_hi");
        expect_at(r + 16, S_PLL, 0, "pu_pll_lo");
        expect_at(r + 16, S_SYS, 1, "pu_sys_hi");
        expect_at(r + 1104, S_RUN, 0, "pu_run_early");
        expect_at(r + 1105, S_RUN, 1, "pu_run");
        expect_at(r + 1105, S_SYS, 0, "pu_sys_lo");
        expect_at(r + 1105, S_LLC, 0, "pu_llc");
        expect_at(r + 16, F + S_RUN, 0, "f_pu_run_early");
        expect_at(r + 17, F + S_RUN, 1, "f_pu_run");
        wait_to(r + 1110);

        // lock loss in RUN
        t = cyc;
        locked = 0;
        expect_at(t + 2, S_SYS, 0, "ll_sys_pre");
        expect_at(t + 3, S_SYS, 1, "ll_sys");
        expect_at(t + 3, S_RUN, 0, "ll_run");
        expect_at(t + 3, S_LLC, 1, "ll_llc");
        expect_at(t + 1100, S_RUN, 0, "ll_rerun_early");
        expect_at(t + 1101, S_RUN, 1, "ll_rerun");
        expect_at(t + 1101, S_SYS, 0, "ll_resys");
        wait_to(t + 10);
        locked = 1;
        wait_to(t + 1110);

        // lock loss, then chatter at STABLE count 500
        t = cyc;
        locked = 0;
        d = t + 513;
        expect_at(t + 3, S_LLC, 2, "ch_llc");
        expect_at(t + 1101, S_RUN, 0, "ch_no_early_run");
        expect_at(d + 1093, S_RUN, 0, "ch_run_early");
        expect_at(d + 1094, S_RUN, 1, "ch_run");
        expect_at(d + 1094, S_LLC, 2, "ch_llc_keep");
        wait_to(t + 10);
        locked = 1;
        wait_to(d);
        locked = 0;
        wait_to(d + 3);
        locked = 1;
        wait_to(d + 1100);

        // reset_req pulse in RUN, then another pulse during HOLD
        q = cyc;
        reset_req = 1;
        expect_at(q + 1, S_SYS, 1, "rq_sys");
        expect_at(q + 1, S_RUN, 0, "rq_run");
        expect_at(q + 64, S_SYS, 1, "rq_sys_end");
        expect_at(q + 65, S_SYS, 0, "rq_sys_lo");
        expect_at(q + 65, S_RUN, 1, "rq_run_back");
        expect_at(q + 65, S_LLC, 2, "rq_llc");
        @(negedge clk);
        reset_req = 0;
        wait_to(q + 30);
        reset_req = 1;
        @(negedge clk);
        reset_req = 0;
        wait_to(q + 70);

        // lock drop coincident with reset_req
        f = cyc;
        locked_f = 0;
        expect_at(f + 3, F + S_LLC, 1, "sim_llc");
        expect_at(f + 3, F + S_RUN, 0, "sim_run");
        expect_at(f + 17, F + S_RUN, 0, "sim_run_early");
        expect_at(f + 18, F + S_RUN, 1, "sim_run_back");
        wait_to(f + 2);
        req_f = 1;
        wait_to(f + 3);
        req_f = 0;
        locked_f = 1;
        wait_to(f + 23);

        // saturation of lock_loss_count
        for (int i = 2; i <= 260; i++) begin
            f = cyc;
            locked_f = 0;
            expect_at(f + 3, F + S_LLC, (i > 255) ? 255 : i, "sat_llc");
            expect_at(f + 18, F + S_RUN, 1, "sat_run");
            wait_to(f + 3);
            locked_f = 1;
            wait_to(f + 23);
        end
        expect_at(cyc + 1, S_SYS, 0, "dflt_still_run");

        // long lock absence: timeout behaviour
        g = cyc;
        locked_f = 0;
        expect_at(g + 3, F + S_LLC, 255, "to_llc_sat");
        expect_at(g + 250, F + S_SYS, 1, "to_sys");
        expect_at(g + 250, F + S_PLL, 0, "to_pll_mid");
`ifdef PLL_LOCK_TIMEOUT_EN
        expect_at(g + 102, F + S_PLL, 0, "to_pll_pre");
        expect_at(g + 103, F + S_PLL, 1, "to_pll_rep1");
        expect_at(g + 106, F + S_PLL, 1, "to_pll_rep1_end");
        expect_at(g + 107, F + S_PLL, 0, "to_pll_rep1_lo");
        expect_at(g + 206, F + S_PLL, 0, "to_pll_pre2");
        expect_at(g + 207, F + S_PLL, 1, "to_pll_rep2");
`else
        expect_at(g + 103, F + S_PLL, 0, "to_pll_none1");
        expect_at(g + 207, F + S_PLL, 0, "to_pll_none2");
`endif
        expect_at(g + 314, F + S_RUN, 0, "to_run_early");
        expect_at(g + 315, F + S_RUN, 1, "to_run");
        wait_to(g + 300);
        locked_f = 1;
        wait_to(g + 320);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
